// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the memory copy engine.
//
// Contents:
//   state_t   - FSM state encoding {IDLE, READ, WRITE, DONE}
//   MEM_DEPTH - data memory depth in bytes
//   addr_t    - 8-bit memory address
//   data_t    - 8-bit memory data
//
// Optional feature macro used by the engine: MEM_COPY_CHECKSUM_EN.
package mem_copy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MEM_DEPTH = 256;

  typedef logic [7:0] addr_t;
  typedef logic [7:0] data_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Bundle of control and data-memory signals for the memory copy engine.
//
// Signals:
//   start, src_addr, dst_addr, len - copy request from the sequencer
//   busy, done                     - status back to the sequencer
//   mem_addr, mem_wr_en, mem_wdata - memory port driven by the engine
//   mem_rdata                      - combinational read data from memory
//   checksum                       - mod-2**DW sum of copied bytes
//                                    (only with MEM_COPY_CHECKSUM_EN)
//
// Modports:
//   master - the copy engine
//   slave  - the sequencer / memory side
interface mem_copy_engine_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);

  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  modport master (
    input  start,
    input  src_addr,
    input  dst_addr,
    input  len,
    output busy,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wdata,
`ifdef MEM_COPY_CHECKSUM_EN
    output checksum,
`endif
    input  mem_rdata
  );

  modport slave (
    output start,
    output src_addr,
    output dst_addr,
    output len,
    input  busy,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata,
`ifdef MEM_COPY_CHECKSUM_EN
    input  checksum,
`endif
    output mem_rdata
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial block copy engine for the data memory port.
//
// Copies len bytes from src_addr to dst_addr, alternating one READ cycle
// (capture combinational read data) with one WRITE cycle. Addresses wrap
// modulo 2**AW and the copy runs strictly forward, so overlapping regions
// with dst above src replicate the leading bytes.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - mem_copy_engine_if master modport (request, status, memory port)
//
// Optional feature: define MEM_COPY_CHECKSUM_EN to add bus.checksum, the
// mod-2**DW sum of all bytes written by the most recent accepted copy.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_copy_engine_if.master   bus
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_READ  = 2'(READ);
  localparam logic [1:0] ST_WRITE = 2'(WRITE);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_byte;
  logic          accept;

  // Start is only honoured in IDLE; anything else is dropped, not queued.
  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign last_byte = (idx_q == (len_q - AW'(1)));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          src_d   = bus.src_addr;
          dst_d   = bus.dst_addr;
          len_d   = bus.len;
          idx_d   = '0;
          state_d = (bus.len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        data_d  = bus.mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (last_byte) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Memory outputs decode straight from state so that the asynchronous
  // reset drops mem_wr_en in the same cycle it is asserted.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    unique case (state_q)
      ST_READ: begin
        bus.mem_addr = src_q + idx_q;
      end
      ST_WRITE: begin
        bus.mem_addr  = dst_q + idx_q;
        bus.mem_wdata = data_q;
        bus.mem_wr_en = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  // Accumulates on each WRITE edge, so the final sum is visible from the
  // DONE cycle and holds until the next accepted start.
  always_comb begin
    checksum_d = checksum_q;
    if (accept) begin
      checksum_d = '0;
    end else if (state_q == ST_WRITE) begin
      checksum_d = checksum_q + data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural
// 256-byte memory (combinational read, write on rising edge).
module tb_mem_copy_engine;

  logic clk;
  logic reset;

  int checks;
  int errors;

  logic [7:0] mem [256];
  logic [7:0] addr_log [16];
  int         log_n;

  logic       poke_en;
  logic [7:0] poke_addr;
  logic [7:0] poke_data;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [7:0] cks_at_done;
`endif

  mem_copy_engine_if #(.AW(8), .DW(8)) mif ();

  mem_copy_engine #(.AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mif.mem_rdata = mem[mif.mem_addr];

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mif.mem_wr_en) begin
      mem[mif.mem_addr] <= mif.mem_wdata;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Issues one request and watches it until done (bounded); inputs are
  // scrambled after the accept edge to exercise the latched copies.
  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         output int done_at, output int wr_cnt);
    done_at = -1;
    wr_cnt  = 0;
    log_n   = 0;
    @(negedge clk);
    mif.start    = 1'b1;
    mif.src_addr = s;
    mif.dst_addr = d;
    mif.len      = l;
    @(negedge clk);
    mif.start    = 1'b0;
    mif.src_addr = ~s;
    mif.dst_addr = ~d;
    mif.len      = 8'h07;
    for (int n = 1; n <= 600; n++) begin
      if (n > 1) @(negedge clk);
      if (mif.done) begin
        done_at = n;
`ifdef MEM_COPY_CHECKSUM_EN
        cks_at_done = mif.checksum;
`endif
        break;
      end
      if (mif.mem_wr_en) wr_cnt++;
      if (log_n < 16) begin
        addr_log[log_n] = mif.mem_addr;
        log_n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({mif.busy, mif.done, mif.mem_wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: busy/done/wr_en=%b expected 000",
               {mif.busy, mif.done, mif.mem_wr_en});
    end
    checks++;
    if ({mif.mem_addr, mif.mem_wdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mem_port: addr/wdata=%h expected 0000", {mif.mem_addr, mif.mem_wdata});
    end
    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int done_at, wr_cnt;
    logic [7:0] exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), exp[i]);
    do_copy(8'h10, 8'h80, 8'd4, done_at, wr_cnt);
    checks++;
    if (done_at !== 9) begin
      errors++;
      $display("FAIL basic_latency: done at cycle %0d expected 9", done_at);
    end
    checks++;
    if (wr_cnt !== 4) begin
      errors++;
      $display("FAIL basic_wr_cycles: got %0d expected 4", wr_cnt);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h80 + 8'(i)] !== exp[i]) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, mem[8'h80 + 8'(i)], exp[i]);
      end
    end
    checks++;
    if (mif.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_after: busy=%b expected 0", mif.busy);
    end
  endtask

  task automatic test_zero_len();
    int done_at, wr_cnt;
    do_copy(8'h10, 8'h80, 8'd0, done_at, wr_cnt);
    checks++;
    if (done_at !== 1) begin
      errors++;
      $display("FAIL zero_latency: done at cycle %0d expected 1", done_at);
    end
    checks++;
    if (wr_cnt !== 0) begin
      errors++;
      $display("FAIL zero_wr_cycles: got %0d expected 0", wr_cnt);
    end
    @(negedge clk);
    checks++;
    if (mem[8'h80] !== 8'hA1) begin
      errors++;
      $display("FAIL zero_mem_unchanged: got %h expected a1", mem[8'h80]);
    end
`ifdef MEM_COPY_CHECKSUM_EN
    checks++;
    if (cks_at_done !== 8'h00) begin
      errors++;
      $display("FAIL zero_checksum: got %h expected 00", cks_at_done);
    end
`endif
  endtask

  task automatic test_wrap();
    int done_at, wr_cnt;
    logic [7:0] src [4];
    logic [7:0] exp_addr [8];
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'h02; exp_addr[2] = 8'hFF; exp_addr[3] = 8'h03;
    exp_addr[4] = 8'h00; exp_addr[5] = 8'h04; exp_addr[6] = 8'h01; exp_addr[7] = 8'h05;
    poke(8'hFE, 8'h11);
    poke(8'hFF, 8'h22);
    poke(8'h00, 8'h33);
    poke(8'h01, 8'h44);
    do_copy(8'hFE, 8'h02, 8'd4, done_at, wr_cnt);
    checks++;
    if (done_at !== 9) begin
      errors++;
      $display("FAIL wrap_latency: done at cycle %0d expected 9", done_at);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (addr_log[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h02 + 8'(i)] !== src[i]) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h expected %h", i, mem[8'h02 + 8'(i)], src[i]);
      end
    end
  endtask

  task automatic test_overlap();
    int done_at, wr_cnt;
    for (int i = 0; i < 4; i++) poke(8'h20 + 8'(i), 8'(i + 1));
    do_copy(8'h20, 8'h21, 8'd3, done_at, wr_cnt);
    checks++;
    if (done_at !== 7) begin
      errors++;
      $display("FAIL overlap_latency: done at cycle %0d expected 7", done_at);
    end
    @(negedge clk);
    checks++;
    if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !== 32'h01010101) begin
      errors++;
      $display("FAIL overlap_data: got %h expected 01010101",
               {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]});
    end
  endtask

  task automatic test_reset_mid();
    int saw_done;
    poke(8'h40, 8'h5A);
    poke(8'h41, 8'h6B);
    poke(8'h42, 8'h7C);
    poke(8'h43, 8'h8D);
    poke(8'h50, 8'h00);
    poke(8'h51, 8'h00);
    @(negedge clk);
    mif.start    = 1'b1;
    mif.src_addr = 8'h40;
    mif.dst_addr = 8'h50;
    mif.len      = 8'd4;
    @(negedge clk);
    mif.start = 1'b0;
    // Now in cycle 1 (READ); advance to cycle 4, the second WRITE.
    repeat (3) @(negedge clk);
    checks++;
    if ({mif.mem_wr_en, mif.mem_addr} !== {1'b1, 8'h51}) begin
      errors++;
      $display("FAIL midreset_pre: wr_en/addr=%b/%h expected 1/51", mif.mem_wr_en, mif.mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({mif.mem_wr_en, mif.busy, mif.done} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_async: wr_en/busy/done=%b expected 000",
               {mif.mem_wr_en, mif.busy, mif.done});
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (mif.done || mif.busy) saw_done++;
    end
    checks++;
    if (saw_done !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: %0d busy/done cycles expected 0", saw_done);
    end
    checks++;
    if ({mem[8'h50], mem[8'h51]} !== 16'h5A00) begin
      errors++;
      $display("FAIL midreset_partial: got %h expected 5a00", {mem[8'h50], mem[8'h51]});
    end
  endtask

  task automatic test_start_while_busy();
    int done_at, wr_cnt, late_busy;
    poke(8'h60, 8'hAA);
    poke(8'h61, 8'hBB);
    poke(8'h90, 8'hEE);
    done_at = -1;
    wr_cnt  = 0;
    @(negedge clk);
    mif.start    = 1'b1;
    mif.src_addr = 8'h60;
    mif.dst_addr = 8'h70;
    mif.len      = 8'd2;
    @(negedge clk);
    mif.start = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (n > 1) @(negedge clk);
      mif.start = 1'b0;
      if (mif.done) begin
        done_at = n;
        break;
      end
      if (mif.mem_wr_en) wr_cnt++;
      if (n == 2) begin
        mif.start    = 1'b1;
        mif.src_addr = 8'h00;
        mif.dst_addr = 8'h90;
        mif.len      = 8'd1;
      end
    end
    late_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (mif.busy) late_busy++;
    end
    checks++;
    if (done_at !== 5) begin
      errors++;
      $display("FAIL busy_start_latency: done at cycle %0d expected 5", done_at);
    end
    checks++;
    if (wr_cnt !== 2 || late_busy !== 0) begin
      errors++;
      $display("FAIL busy_start_ignored: wr=%0d late_busy=%0d expected 2/0", wr_cnt, late_busy);
    end
    checks++;
    if ({mem[8'h70], mem[8'h71], mem[8'h90]} !== 24'hAABBEE) begin
      errors++;
      $display("FAIL busy_start_data: got %h expected aabbee",
               {mem[8'h70], mem[8'h71], mem[8'h90]});
    end
  endtask

`ifdef MEM_COPY_CHECKSUM_EN
  task automatic test_checksum();
    int done_at, wr_cnt;
    poke(8'hA0, 8'h10);
    poke(8'hA1, 8'h20);
    do_copy(8'hA0, 8'hB0, 8'd2, done_at, wr_cnt);
    checks++;
    if (cks_at_done !== 8'h30) begin
      errors++;
      $display("FAIL checksum_small: got %h expected 30", cks_at_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (mif.checksum !== 8'h30) begin
      errors++;
      $display("FAIL checksum_hold: got %h expected 30", mif.checksum);
    end
    poke(8'hC0, 8'hFF);
    poke(8'hC1, 8'h01);
    poke(8'hC2, 8'h80);
    poke(8'hC3, 8'h80);
    do_copy(8'hC0, 8'hD0, 8'd4, done_at, wr_cnt);
    checks++;
    if (cks_at_done !== 8'h00) begin
      errors++;
      $display("FAIL checksum_wrap: got %h expected 00", cks_at_done);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    poke_en      = 1'b0;
    poke_addr    = 8'h00;
    poke_data    = 8'h00;
    mif.start    = 1'b0;
    mif.src_addr = 8'h00;
    mif.dst_addr = 8'h00;
    mif.len      = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_overlap();
    test_reset_mid();
    test_start_while_busy();
`ifdef MEM_COPY_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
